// File: rtl/conv_window_scheduler.sv
// Sequencer for a single-channel convolution layer: walks output rows and lane groups,
// times the MAC window, captures lane results and hands them downstream with valid/ready.
module conv_window_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int D           = 1,
    parameter int H           = 32,
    parameter int W           = 32,
    parameter int F           = 5,
    parameter int LANES       = 14,
    parameter int COORD_WIDTH = 6,
    parameter int IDX_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [COORD_WIDTH-1:0]        row_number,
    output logic [COORD_WIDTH-1:0]        column,
    output logic                          unit_clear,
    input  logic [LANES*DATA_WIDTH-1:0]   unit_results,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [IDX_WIDTH-1:0]          out_index
);
    localparam int OUT_H      = H - F + 1;
    localparam int OUT_W      = W - F + 1;
    localparam int GROUPS     = OUT_W / LANES;
    localparam int MAC_CYCLES = D * F * F + 2;
    localparam int BLOCKS     = OUT_H * GROUPS;
    localparam int CNT_W      = $clog2(MAC_CYCLES);

    if ((OUT_W % LANES) != 0 || BLOCKS >= (1 << IDX_WIDTH) ||
        OUT_H > (1 << COORD_WIDTH) || OUT_W > (1 << COORD_WIDTH)) begin : g_param_check
        $error("conv_window_scheduler: illegal parameter set");
    end

    localparam logic [COORD_WIDTH-1:0] LANES_C  = COORD_WIDTH'(LANES);
    localparam logic [COORD_WIDTH-1:0] LAST_COL = COORD_WIDTH'(OUT_W - LANES);
    localparam logic [COORD_WIDTH-1:0] LAST_ROW = COORD_WIDTH'(OUT_H - 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(MAC_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_EMIT, S_DONE} state_t;

    state_t                        state_q,      state_d;
    logic [COORD_WIDTH-1:0]        row_number_q, row_number_d;
    logic [COORD_WIDTH-1:0]        column_q,     column_d;
    logic [IDX_WIDTH-1:0]          out_index_q,  out_index_d;
    logic [CNT_W-1:0]              mac_cnt_q,    mac_cnt_d;
    logic                          out_valid_q,  out_valid_d;
    logic [LANES*DATA_WIDTH-1:0]   out_data_q,   out_data_d;
    logic                          busy_q,       busy_d;
    logic                          done_q,       done_d;
    logic                          unit_clear_q, unit_clear_d;

    always_comb begin
        state_d      = state_q;
        row_number_d = row_number_q;
        column_d     = column_q;
        out_index_d  = out_index_q;
        mac_cnt_d    = mac_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        unit_clear_d = unit_clear_q;
        case (state_q)
            S_IDLE: begin
                busy_d       = 1'b0;
                unit_clear_d = 1'b1;
                if (start) begin
                    state_d      = S_CLEAR;
                    busy_d       = 1'b1;
                    row_number_d = '0;
                    column_d     = '0;
                    out_index_d  = '0;
                    mac_cnt_d    = '0;
                end
            end
            S_CLEAR: begin
                state_d      = S_ACCUM;
                unit_clear_d = 1'b0;
                mac_cnt_d    = '0;
            end
            S_ACCUM: begin
                // Lane results are sampled on the edge that closes the MAC window.
                if (mac_cnt_q == CNT_LAST) begin
                    state_d      = S_EMIT;
                    out_data_d   = unit_results;
                    out_valid_d  = 1'b1;
                    unit_clear_d = 1'b1;
                    mac_cnt_d    = '0;
                end else begin
                    mac_cnt_d = mac_cnt_q + CNT_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_index_d = out_index_q + IDX_WIDTH'(1);
                    state_d     = S_CLEAR;
                    if (column_q == LAST_COL) begin
                        column_d = '0;
                        if (row_number_q == LAST_ROW) begin
                            row_number_d = '0;
                            state_d      = S_DONE;
                            done_d       = 1'b1;
                        end else begin
                            row_number_d = row_number_q + COORD_WIDTH'(1);
                        end
                    end else begin
                        column_d = column_q + LANES_C;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            row_number_q <= '0;
            column_q     <= '0;
            out_index_q  <= '0;
            mac_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            unit_clear_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            row_number_q <= row_number_d;
            column_q     <= column_d;
            out_index_q  <= out_index_d;
            mac_cnt_q    <= mac_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            unit_clear_q <= unit_clear_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign row_number = row_number_q;
    assign column     = column_q;
    assign unit_clear = unit_clear_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: block order, timing, back-pressure, start/reset handling,
// with lane results generated from the coordinates and a salt drawn per pass.
module tb_conv_window_scheduler;
    localparam int DW      = 16;
    localparam int LANES   = 14;
    localparam int CW      = 6;
    localparam int IW      = 8;
    localparam int OUT_H   = 32 - 5 + 1;
    localparam int OUT_W   = 32 - 5 + 1;
    localparam int GROUPS  = OUT_W / LANES;
    localparam int MAC     = 1 * 5 * 5 + 2;
    localparam int BLOCKS  = OUT_H * GROUPS;
    localparam int PASS_CY = BLOCKS * (MAC + 2);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [CW-1:0]         row_number;
    logic [CW-1:0]         column;
    logic                  unit_clear;
    logic [LANES*DW-1:0]   unit_results;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*DW-1:0]   out_data;
    logic [IW-1:0]         out_index;
    logic [31:0]           salt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_window_scheduler #(
        .DATA_WIDTH(DW), .D(1), .H(32), .W(32), .F(5),
        .LANES(LANES), .COORD_WIDTH(CW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .row_number(row_number), .column(column), .unit_clear(unit_clear),
        .unit_results(unit_results), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index)
    );

    // Lane i of the group starting at column c on row r; lane 0 in the MSBs.
    function automatic logic [LANES*DW-1:0] model_data(input logic [31:0] s, input int r, input int c);
        logic [LANES*DW-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++)
            d[(LANES-1-i)*DW +: DW] = DW'(s ^ 32'(r * 977) ^ 32'((c + i) * 131) ^ 32'(i << 9));
        return d;
    endfunction

    always_comb unit_results = model_data(salt, int'(row_number), int'(column));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_block(input int k, input string ph);
        check({ph, "_index"}, out_index, k);
        check({ph, "_row"}, row_number, k / GROUPS);
        check({ph, "_col"}, column, (k % GROUPS) * LANES);
        check({ph, "_data"}, out_data, model_data(salt, k / GROUPS, (k % GROUPS) * LANES));
        check({ph, "_busy"}, busy, 1);
    endtask

    task automatic run_pass(input int stall_blk, input int stall_len, input bit poke,
                            input int abort_blk, input bit hold_start);
        int cyc;
        int hs;
        int low;
        int clear_cyc;
        int stall_left;
        bit ended;
        bit aborted;
        cyc = 0; hs = 0; low = 0; clear_cyc = -1; stall_left = stall_len;
        ended = 1'b0; aborted = 1'b0;
        salt  = $urandom;
        start = 1'b1;
        while (!ended && cyc < PASS_CY + 2000) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) start = 1'b0;
            out_ready = 1'b1;
            if (clear_cyc < 0 && busy) begin
                clear_cyc = cyc;
                check("launch_latency", cyc, 1);
            end
            if (!unit_clear) low++;
            if (done) begin
                check("done_cycles", cyc - clear_cyc, PASS_CY + stall_len);
                check("done_blocks", hs, BLOCKS);
                check("done_busy", busy, 1);
                check("done_row", row_number, 0);
                check("done_col", column, 0);
                ended = 1'b1;
            end else if (out_valid) begin
                if (hs == abort_blk) begin
                    reset     = 1'b0;
                    out_ready = 1'b0;
                    @(negedge clk);
                    reset = 1'b1;
                    check("abort_valid", out_valid, 0);
                    check("abort_index", out_index, 0);
                    check("abort_busy", busy, 0);
                    check("abort_clear", unit_clear, 1);
                    check("abort_row", row_number, 0);
                    check("abort_col", column, 0);
                    check("abort_data", out_data, 0);
                    aborted = 1'b1;
                    ended   = 1'b1;
                end else if (hs == stall_blk && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check_block(hs, "stall");
                end else begin
                    check_block(hs, "hs");
                    check("clear_low_cycles", low, MAC);
                    hs++;
                    low = 0;
                    if (poke && hs % 7 == 5) start = 1'b1;
                end
            end else if (poke && !unit_clear && low == 10 && hs % 7 == 2) begin
                start = 1'b1;
            end
        end
        check("pass_ended", ended, 1);
        out_ready = 1'b1;
        start     = hold_start;
        if (ended && !aborted) begin
            @(negedge clk);
            check("idle_done", done, 0);
            check("idle_busy", busy, 0);
            check("idle_clear", unit_clear, 1);
            check("idle_valid", out_valid, 0);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; salt = '0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_clear", unit_clear, 1);
            check("rst_index", out_index, 0);
            check("rst_row", row_number, 0);
            check("rst_col", column, 0);
            check("rst_data", out_data, 0);
        end

        run_pass(-1, 0, 1'b0, -1, 1'b0);
        run_pass(3, 10, 1'b0, -1, 1'b0);
        run_pass(-1, 0, 1'b1, -1, 1'b0);
        run_pass(-1, 0, 1'b0, 20, 1'b0);
        run_pass(-1, 0, 1'b0, -1, 1'b0);
        run_pass(-1, 0, 1'b0, -1, 1'b1);
        run_pass(-1, 0, 1'b0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
